// File: rtl/seg7_scan.sv
// Scanned driver for an 8-digit common-select seven-segment display.
// The CPU word is double-buffered and only swapped into the visible register at frame boundaries.
module seg7_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  dig_en,
  input  logic        blank_lz,
  output logic [7:0]  num_csn,
  output logic [6:0]  num_a_g,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TERM_VAL  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_VAL = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic [31:0]   disp;
  logic          term;
  logic          boundary;
  logic [3:0]    nibble;
  logic          upper_zero;
  logic          vis;
  logic [6:0]    seg;

  assign term     = (cnt == TERM_VAL);
  assign boundary = term && (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= term ? '0 : cnt + 1'b1;
      if (term) idx <= idx + 3'd1;
    end
  end

  // A write landing on the boundary cycle goes straight to disp so it is not delayed a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      disp       <= '0;
      frame_done <= 1'b0;
    end else begin
      if (wr_en) shadow <= wr_data;
      if (boundary) disp <= wr_en ? wr_data : shadow;
      frame_done <= boundary;
    end
  end

  // Leading-zero test: every nibble from the current digit upward is zero.
  always_comb begin
    nibble     = disp[{idx, 2'b00} +: 4];
    upper_zero = ((disp >> {idx, 2'b00}) == 32'd0);
    vis        = dig_en[idx] && !(blank_lz && (idx != 3'd0) && upper_zero);
  end

  always_comb begin
    case (nibble)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end

  // Registered outputs: a single select flop set means only one digit can ever be driven low.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_csn <= 8'hFF;
      num_a_g <= 7'h7F;
    end else if ((cnt < BLANK_VAL) || !vis) begin
      num_csn <= 8'hFF;
      num_a_g <= 7'h7F;
    end else begin
      num_csn <= ~(8'b1 << idx);
      num_a_g <= seg;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed scenarios plus random traffic,
// checked against a cycle-count based reference of the scan.
module tb_seg7_scan;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FRAME = 8 * SD;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  dig_en;
  logic        blank_lz;
  logic [7:0]  num_csn;
  logic [6:0]  num_a_g;
  logic        frame_done;

  int tests;
  int fails;

  // Reference state: cycles since reset plus the architectural buffers.
  int          t_ref;
  logic [31:0] shadow_ref;
  logic [31:0] disp_ref;

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .dig_en(dig_en), .blank_lz(blank_lz),
    .num_csn(num_csn), .num_a_g(num_a_g), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic void refOut(input int t, input logic [31:0] d, input logic [7:0] en,
                                 input logic lz, output logic [7:0] csn, output logic [6:0] ag);
    int c, i;
    logic [31:0] upper;
    logic vis;
    c = t % SD;
    i = (t / SD) % 8;
    upper = d >> (4 * i);
    vis = en[i] && !(lz && i != 0 && upper == 32'd0);
    if (c < BC || !vis) begin
      csn = 8'hFF;
      ag  = 7'h7F;
    end else begin
      csn = ~(8'h01 << i);
      ag  = hex_tab[upper[3:0]];
    end
  endfunction

  // One clock: predict from the pre-edge state, advance the model, compare after the edge.
  task automatic step();
    logic [7:0] e_csn;
    logic [6:0] e_ag;
    logic       e_fd;
    if (rst) begin
      e_csn = 8'hFF; e_ag = 7'h7F; e_fd = 1'b0;
      t_ref = 0; shadow_ref = '0; disp_ref = '0;
    end else begin
      refOut(t_ref, disp_ref, dig_en, blank_lz, e_csn, e_ag);
      e_fd = (t_ref % FRAME == FRAME - 1);
      if (e_fd) disp_ref = wr_en ? wr_data : shadow_ref;
      if (wr_en) shadow_ref = wr_data;
      t_ref++;
    end
    @(posedge clk);
    #1;
    checkOutput("num_csn", {24'd0, num_csn}, {24'd0, e_csn});
    checkOutput("num_a_g", {25'd0, num_a_g}, {25'd0, e_ag});
    checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    checkOutput("one_hot_sel", {31'd0, ($countones(~num_csn) <= 1)}, 32'd1);
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] data, input int n);
    wr_en = we;
    wr_data = data;
    step();
    wr_en = 1'b0;
    for (int k = 1; k < n; k++) step();
  endtask

  task automatic runTo(input int phase);
    for (int k = 0; k < FRAME && (t_ref % FRAME) != phase; k++) step();
  endtask

  initial begin
    tests = 0; fails = 0;
    t_ref = 0; shadow_ref = '0; disp_ref = '0;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; dig_en = 8'hFF; blank_lz = 1'b0;

    for (int k = 0; k < 10; k++) step();
    rst = 1'b0;

    applyStimulus(1'b1, 32'h12345678, 2 * FRAME + 4);

    blank_lz = 1'b1;
    applyStimulus(1'b1, 32'h000000A5, 2 * FRAME);
    blank_lz = 1'b0;
    applyStimulus(1'b0, 32'h0, FRAME);

    applyStimulus(1'b1, 32'h12345678, 2 * FRAME);
    runTo(3 * SD);
    applyStimulus(1'b1, 32'hFFFFFFFF, 2 * FRAME);

    runTo(FRAME - 1);
    applyStimulus(1'b1, 32'hDEADBEEF, FRAME + 2);

    runTo(2);
    applyStimulus(1'b1, 32'h11111111, 5);
    applyStimulus(1'b1, 32'h22222222, 2 * FRAME);

    dig_en = 8'h0F;
    applyStimulus(1'b0, 32'h0, 2 * FRAME);
    dig_en = 8'hFF;

    runTo(5 * SD + 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, FRAME + 2);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 3) dig_en = 8'($urandom);
      if ($urandom_range(0, 99) < 3) blank_lz = 1'($urandom);
      rst = ($urandom_range(0, 999) < 2);
      wr_en = ($urandom_range(0, 99) < 4);
      wr_data = ($urandom_range(0, 3) == 0) ? (32'($urandom) >> (4 * $urandom_range(0, 7)))
                                            : 32'($urandom);
      step();
    end
    rst = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
